// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//   MODE_ADD / MODE_SUB : encodings of the add/sub unit's mode input
//   DEF_WIDTH / DEF_SLICE: default operand width and bits per pipeline stage
package alu_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

endpackage

// File: rtl/slice_adder.sv
// Combinational SLICE-bit adder used for one pipeline stage of the add/sub unit.
//   a, b : slice operands
//   cin  : carry into bit 0 of the slice
//   s    : slice sum
//   cout : carry out of the slice MSB
module slice_adder #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit add/subtract unit. The word is added SLICE bits per
// stage, so latency is NSTAGE = WIDTH/SLICE cycles at one op per cycle.
//   clk, reset_n           : clock, asynchronous active-low reset
//   in_valid / in_ready    : operand handshake (in_ready is combinational)
//   in1, in2, carry_in     : operands; carry_in is used for ADD only
//   mode                   : MODE_ADD (in1+in2+carry_in) or MODE_SUB (in1-in2)
//   out_valid / out_ready  : result handshake with backpressure
//   sum, carry_out         : result; for SUB carry_out = 1 means no borrow
//   overflow, zero, negative: signed overflow, sum == 0, sum MSB
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             carry_in,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NSTAGE = WIDTH / SLICE;

  if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_width
    $error("pipelined_add_sub: WIDTH must be a non-zero multiple of SLICE");
  end

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic f_overflow(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // The whole pipe moves only when the output register is free or being taken.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = reset_n && adv;
  assign accept   = in_valid && in_ready;

  // Subtraction is A + ~B + 1; the caller's carry_in is ignored for SUB.
  assign b_eff = (mode == MODE_ADD) ? in2 : ~in2;
  assign c_eff = (mode == MODE_SUB) ? 1'b1 : carry_in;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
    localparam int REM = WIDTH - k * SLICE;   // operand bits not yet added
    localparam int LO  = k * SLICE;           // result bits already completed

    logic [REM-1:0]      a_rem;
    logic [REM-1:0]      b_rem;
    logic                cin_k;
    logic                vld_k;
    logic [SLICE-1:0]    s_k;
    logic                cout_k;
    logic [LO+SLICE-1:0] res_nxt;

    if (k == 0) begin : g_src
      assign a_rem   = in1;
      assign b_rem   = b_eff;
      assign cin_k   = c_eff;
      assign vld_k   = accept;
      assign res_nxt = s_k;
    end else begin : g_src
      assign a_rem   = g_stg[k-1].g_mid.a_p;
      assign b_rem   = g_stg[k-1].g_mid.b_p;
      assign cin_k   = g_stg[k-1].g_mid.c_p;
      assign vld_k   = g_stg[k-1].g_mid.vld_p;
      assign res_nxt = {s_k, g_stg[k-1].g_mid.res_p};
    end

    slice_adder #(.SLICE(SLICE)) u_slice (
      .a    (a_rem[SLICE-1:0]),
      .b    (b_rem[SLICE-1:0]),
      .cin  (cin_k),
      .s    (s_k),
      .cout (cout_k)
    );

    if (k < NSTAGE - 1) begin : g_mid
      // ---- stage k register: carry, finished low slices, skewed high operand bits
      logic                vld_p;
      logic                c_p;
      logic [REM-SLICE-1:0] a_p;
      logic [REM-SLICE-1:0] b_p;
      logic [LO+SLICE-1:0] res_p;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_p <= 1'b0;
        end else if (adv) begin
          vld_p <= vld_k;
        end
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          c_p   <= cout_k;
          a_p   <= a_rem[REM-1:SLICE];
          b_p   <= b_rem[REM-1:SLICE];
          res_p <= res_nxt;
        end
      end
    end else begin : g_last
      // ---- final stage register: result and flags; held while no new result
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          carry_out <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b0;
          negative  <= 1'b0;
        end else if (adv) begin
          out_valid <= vld_k;
          if (vld_k) begin
            sum       <= res_nxt;
            carry_out <= cout_k;
            overflow  <= f_overflow(a_rem[REM-1], b_rem[REM-1], s_k[SLICE-1]);
            zero      <= (res_nxt == '0);
            negative  <= res_nxt[WIDTH-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
module tb_pipelined_add_sub;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset_n;

  // Main instance: WIDTH=32, SLICE=8
  logic        in_valid, in_ready, carry_in, mode, out_valid, out_ready;
  logic [31:0] in1, in2, sum;
  logic        carry_out, overflow, zero, negative;

  pipelined_add_sub #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .carry_in(carry_in), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow), .zero(zero), .negative(negative)
  );

  // WIDTH=16, SLICE=4
  logic        b_in_valid, b_in_ready, b_carry_in, b_mode, b_out_valid, b_out_ready;
  logic [15:0] b_in1, b_in2, b_sum;
  logic        b_carry_out, b_overflow, b_zero, b_negative;

  pipelined_add_sub #(.WIDTH(16), .SLICE(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in1(b_in1), .in2(b_in2), .carry_in(b_carry_in), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .sum(b_sum),
    .carry_out(b_carry_out), .overflow(b_overflow), .zero(b_zero), .negative(b_negative)
  );

  // WIDTH=32, SLICE=32 (single stage)
  logic        c_in_valid, c_in_ready, c_carry_in, c_mode, c_out_valid, c_out_ready;
  logic [31:0] c_in1, c_in2, c_sum;
  logic        c_carry_out, c_overflow, c_zero, c_negative;

  pipelined_add_sub #(.WIDTH(32), .SLICE(32)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in1(c_in1), .in2(c_in2), .carry_in(c_carry_in), .mode(c_mode),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .sum(c_sum),
    .carry_out(c_carry_out), .overflow(c_overflow), .zero(c_zero), .negative(c_negative)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        md;
    logic [31:0] s;
    logic [3:0]  fl;   // {carry_out, overflow, zero, negative}
  } vec_t;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
  } res_t;

  vec_t        tbl [12];
  vec_t        post_rst;
  int          lat;
  logic [31:0] st_exp [6];
  int          hs_cyc [6];
  int          idx;
  logic        any_v;

  localparam int NR = 24;
  logic [31:0] ra [NR];
  logic [31:0] rb [NR];
  logic        rci [NR];
  logic        rmd [NR];
  int          acc_cyc [NR];
  int          kb, kc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout/unexpected required=handshake", name);
  endtask

  // Whole-word reference for a w-bit unit (w <= 32).
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic md);
    logic [32:0] full;
    logic [31:0] mask, am, be;
    res_t r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am   = a & mask;
    be   = (md ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, be} + {32'd0, (md ? 1'b1 : ci)};
    r.s  = full[31:0] & mask;
    r.co = full[w];
    r.ov = (am[w-1] == be[w-1]) && (r.s[w-1] != am[w-1]);
    r.z  = (r.s == 32'd0);
    r.n  = r.s[w-1];
    return r;
  endfunction

  // One isolated op on the main instance; lat = edges from accept to out_valid.
  task automatic main_op(input vec_t v, output int l);
    @(negedge clk);
    in1 = v.a; in2 = v.b; carry_in = v.ci; mode = v.md; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 16) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in1 = '0; in2 = '0; carry_in = 1'b0; mode = MODE_ADD; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in1 = '0; b_in2 = '0; b_carry_in = 1'b0; b_mode = MODE_ADD; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in1 = '0; c_in2 = '0; c_carry_in = 1'b0; c_mode = MODE_ADD; c_out_ready = 1'b1;

    tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, 32'h0000_0000, 4'b1010};
    tbl[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, 32'h8000_0000, 4'b0101};
    tbl[2]  = '{32'h0000_0010, 32'h0000_0020, 1'b1, MODE_ADD, 32'h0000_0031, 4'b0000};
    tbl[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, MODE_SUB, 32'hFFFF_FFFE, 4'b0001};
    tbl[4]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, MODE_SUB, 32'h0000_0002, 4'b1000};
    tbl[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, MODE_SUB, 32'h7FFF_FFFF, 4'b1100};
    tbl[6]  = '{32'h0000_0009, 32'h0000_0009, 1'b1, MODE_SUB, 32'h0000_0000, 4'b1010};
    tbl[7]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, MODE_ADD, 32'h0000_0100, 4'b0000};
    tbl[8]  = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, MODE_ADD, 32'h0001_0000, 4'b0000};
    tbl[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, MODE_ADD, 32'h0000_0000, 4'b1110};
    tbl[10] = '{32'h0000_0000, 32'h0000_0001, 1'b0, MODE_SUB, 32'hFFFF_FFFF, 4'b0001};
    tbl[11] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, MODE_ADD, 32'hACF1_3568, 4'b0001};
    post_rst = '{32'h1111_1111, 32'h2222_2222, 1'b0, MODE_ADD, 32'h3333_3333, 4'b0000};

    st_exp[0] = 32'h0101_0102; st_exp[1] = 32'h0202_0204; st_exp[2] = 32'h0303_0306;
    st_exp[3] = 32'h0404_0408; st_exp[4] = 32'h0505_050A; st_exp[5] = 32'h0606_060C;

    ra[0] = 32'h0000_FFFF; rb[0] = 32'h1; rci[0] = 1'b0; rmd[0] = MODE_ADD;
    ra[1] = 32'hFFFF_FFFF; rb[1] = 32'h1; rci[1] = 1'b0; rmd[1] = MODE_ADD;
    ra[2] = 32'h8000_8000; rb[2] = 32'h1; rci[2] = 1'b0; rmd[2] = MODE_SUB;
    ra[3] = 32'h0000_0005; rb[3] = 32'h5; rci[3] = 1'b1; rmd[3] = MODE_SUB;
    for (int i = 4; i < NR; i++) begin
      ra[i]  = $urandom;
      rb[i]  = $urandom;
      rci[i] = 1'($urandom_range(0, 1));
      rmd[i] = 1'($urandom_range(0, 1));
    end

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_flags", 64'({carry_out, overflow, zero, negative}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'(1));

    // Directed vectors, one at a time
    for (int i = 0; i < 12; i++) begin
      main_op(tbl[i], lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
      chk($sformatf("vec%0d_sum", i), 64'(sum), 64'(tbl[i].s));
      chk($sformatf("vec%0d_flags", i), 64'({carry_out, overflow, zero, negative}), 64'(tbl[i].fl));
    end

    // Stream of 6 with a 3-cycle output stall after the first result
    @(negedge clk);
    idx = 0;
    out_ready = 1'b1;
    fork
      begin : drv
        int w;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          in1 = 32'h0101_0101 * (i + 1); in2 = 32'(i + 1);
          carry_in = 1'b0; mode = MODE_ADD; in_valid = 1'b1;
          #1;
          w = 0;
          while (!in_ready && w < 20) begin
            @(negedge clk); #1;
            w++;
          end
          if (w >= 20) fail_now("stream_drv_wait");
          @(posedge clk);
        end
        #1 in_valid = 1'b0;
      end
      begin : mon
        for (int c = 0; c < 40; c++) begin
          @(negedge clk); #1;
          if (out_valid && !out_ready) begin
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            if (idx < 6) chk("stall_hold_sum", 64'(sum), 64'(st_exp[idx]));
          end
          if (out_valid && out_ready) begin
            if (idx < 6) begin
              chk($sformatf("stream_sum%0d", idx), 64'(sum), 64'(st_exp[idx]));
              hs_cyc[idx] = cyc;
            end else begin
              fail_now("stream_extra_result");
            end
            idx++;
          end
        end
      end
      begin : stl
        int w;
        w = 0;
        while (idx < 1 && w < 40) begin
          @(posedge clk);
          w++;
        end
        #2 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    chk("stream_count", 64'(idx), 64'(6));
    chk("stream_span", 64'(hs_cyc[5] - hs_cyc[0]), 64'(8));

    // Reset with ops in flight
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in1 = 32'(i + 1); in2 = 32'h1; carry_in = 1'b0; mode = MODE_ADD; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_mid_pre_valid", 64'(out_valid), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
    chk("rst_mid_sum", 64'(sum), 64'(0));
    chk("rst_mid_flags", 64'({carry_out, overflow, zero, negative}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    any_v = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      any_v = any_v | out_valid;
    end
    chk("rst_mid_no_residue", 64'(any_v), 64'(0));
    main_op(post_rst, lat);
    chk("post_rst_latency", 64'(lat), 64'(4));
    chk("post_rst_sum", 64'(sum), 64'(post_rst.s));

    // 16/4 and 32/32 instances, streaming against the reference model
    kb = 0;
    kc = 0;
    fork
      begin : drv2
        for (int i = 0; i < NR; i++) begin
          @(negedge clk);
          if (!b_in_ready || !c_in_ready) fail_now("alt_in_ready");
          b_in1 = ra[i][15:0]; b_in2 = rb[i][15:0]; b_carry_in = rci[i]; b_mode = rmd[i];
          c_in1 = ra[i];       c_in2 = rb[i];       c_carry_in = rci[i]; c_mode = rmd[i];
          b_in_valid = 1'b1;
          c_in_valid = 1'b1;
          acc_cyc[i] = cyc + 1;
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
      end
      begin : mon2
        res_t r;
        for (int c = 0; c < NR + 10; c++) begin
          @(negedge clk); #1;
          if (b_out_valid) begin
            if (kb < NR) begin
              r = model(16, ra[kb], rb[kb], rci[kb], rmd[kb]);
              chk($sformatf("w16_sum%0d", kb), 64'(b_sum), 64'(r.s[15:0]));
              chk($sformatf("w16_flags%0d", kb), 64'({b_carry_out, b_overflow, b_zero, b_negative}),
                  64'({r.co, r.ov, r.z, r.n}));
              chk($sformatf("w16_latency%0d", kb), 64'(cyc), 64'(acc_cyc[kb] + 3));
              if (kb == 0) chk("w16_ffff_plus_1", 64'({b_carry_out, b_sum}), 64'(17'h1_0000));
            end else begin
              fail_now("w16_extra_result");
            end
            kb++;
          end
          if (c_out_valid) begin
            if (kc < NR) begin
              r = model(32, ra[kc], rb[kc], rci[kc], rmd[kc]);
              chk($sformatf("w32s32_sum%0d", kc), 64'(c_sum), 64'(r.s));
              chk($sformatf("w32s32_flags%0d", kc), 64'({c_carry_out, c_overflow, c_zero, c_negative}),
                  64'({r.co, r.ov, r.z, r.n}));
              chk($sformatf("w32s32_latency%0d", kc), 64'(cyc), 64'(acc_cyc[kc]));
            end else begin
              fail_now("w32s32_extra_result");
            end
            kc++;
          end
        end
      end
    join
    chk("w16_count", 64'(kb), 64'(NR));
    chk("w32s32_count", 64'(kc), 64'(NR));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the fixed 32-bit ripple adder.
- The WIDTH-bit operation is split into SLICE-bit ripple slices, with one pipeline register between slices.
- Full throughput (1 op/cycle) with valid/ready handshake and backpressure.
- Produces sum, carry, signed overflow, zero and negative flags; feeds the ALU result mux.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
SLICE, 8, bits added per pipeline stage; NSTAGE = WIDTH/SLICE = latency in cycles.

Ports:
clk  input  1  single clock; all state on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  unit accepts operands this cycle
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
carry_in  input  1  carry into bit 0 (ADD only)
mode  input  1  0 = ADD (in1+in2+carry_in), 1 = SUB (in1-in2)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
carry_out  output  1  carry out of MSB; for SUB, 1 = no borrow
overflow  output  1  two's-complement signed overflow
zero  output  1  sum == 0
negative  output  1  sum[WIDTH-1]

Behaviour:
- Reset, asynchronous, reset_n low:
  - all stage valid bits, out_valid, sum and all flags clear to 0 immediately;
  - in_ready is 0 while reset_n is low.
- Reset mid-operation discards all in-flight ops; no partial result ever appears.
- Advance condition: adv = !(out_valid && !out_ready). in_ready = adv, combinational, no dependence on in_valid.
- Accept occurs when in_valid && in_ready. Stage 0 captures in1, the effective B and the effective carry:
  - ADD: B = in2, c = carry_in.
  - SUB: B = ~in2, c = 1; carry_in is ignored.
- Stage k (0..NSTAGE-1) adds slice k of A and B plus the carry from stage k-1, registered.
  - Higher slices of A/B ride along in skew registers.
  - Completed lower sum slices ride along in result registers.
- When adv = 0, every stage register holds; outputs are stable and no op is lost or duplicated.
- When adv = 1 and there is no accept, a bubble (valid = 0) enters stage 0.
- Latency: an op accepted at edge N is presented with out_valid = 1 after edge N+NSTAGE-1, if not stalled. Each stall cycle adds one.
- Final stage flags:
  - carry_out = carry out of the MSB slice.
  - overflow = (A[msb] == B[msb]) && (sum[msb] != A[msb]), using effective B.
  - zero = (sum == 0); negative = sum[msb].
- Flags and sum are only meaningful when out_valid = 1. They hold their last value otherwise; there is no forced clear except at reset.
- Ordering is strict FIFO; back-to-back accepts with no bubbles are required.
- Simultaneous output handshake and input accept in one cycle is legal and keeps full throughput.
- NSTAGE = 1 (SLICE == WIDTH) is legal: latency 1, single register stage.
- WIDTH % SLICE != 0 is an elaboration error (generate-time check).

Decomposition:
- Shared package alu_pkg:
  - mode encodings MODE_ADD = 1'b0, MODE_SUB = 1'b1;
  - default WIDTH and SLICE constants.
- Sub-module slice_adder (SLICE-bit combinational ripple adder: a, b, cin -> s, cout), instantiated NSTAGE times in a generate loop.
- The pipeline/handshake/skew logic lives in pipelined_add_sub.

Test Plan:
1. WIDTH=32, SLICE=8, ADD 0xFFFFFFFF + 0x00000001, carry_in=0 -> after 4 cycles: sum=0x00000000, carry_out=1, zero=1, overflow=0, negative=0.
2. ADD 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, overflow=1, negative=1, carry_out=0. ADD 0x00000010 + 0x00000020, carry_in=1 -> sum=0x00000031.
3. SUB 5 - 7 -> sum=0xFFFFFFFE, carry_out=0, negative=1. SUB 7 - 5 -> sum=0x00000002, carry_out=1. SUB 0x80000000 - 1 -> sum=0x7FFFFFFF, overflow=1.
4. Stream 6 back-to-back ops; hold out_ready=0 for 3 cycles mid-stream:
   - in_ready drops within the same cycle;
   - sum/flags stay stable;
   - all 6 results emerge in order, none dropped or duplicated;
   - after release, throughput returns to 1/cycle.
5. Reset mid-flight: pulse reset_n low with 3 ops in the pipe -> out_valid=0 immediately and stays 0 after release until a new op completes NSTAGE cycles later.
6. Re-elaborate with WIDTH=16, SLICE=4 (latency 4) and WIDTH=32, SLICE=32 (latency 1):
   - random add/sub ops checked against a reference model with full flags;
   - 0xFFFF + 0x0001 -> sum=0x0000, carry_out=1.
